imuldiv_mul_accum_initiator: RTL and testbench

Requester-side client for the iterative multiplier's mulreq/mulresp val/rdy interface.
- Accepts a command giving a vector length, then consumes that many (a, b) operand pairs from an input stream.
- Issues one multiply request per pair, with at most 1 outstanding, and accumulates the 64-bit products.
- Returns the 64-bit sum on a val/rdy result port.
- Sits between the processor-side dot-product logic and an imuldiv multiplier instance.

---
 rtl/imuldiv_mul_accum_pkg.sv | 16 +
 rtl/imuldiv_mul_accum_if.sv | 56 +++++
 rtl/imuldiv_mul_accum_dpath.sv | 80 ++++++++
 rtl/imuldiv_mul_accum_initiator.sv | 133 +++++++++++++
 tb/tb_imuldiv_mul_accum_initiator.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/imuldiv_mul_accum_pkg.sv
// Shared types and widths for the multiply-accumulate requester.
// Optional overflow flag build: IMULDIV_MUL_ACCUM_OVF_EN.
package imuldiv_mul_accum_pkg;

   localparam int unsigned OPND_W = 32;
   localparam int unsigned PROD_W = 64;

   typedef enum logic [2:0] {
      STATE_IDLE = 3'd0,
      STATE_LOAD = 3'd1,
      STATE_REQ  = 3'd2,
      STATE_WAIT = 3'd3,
      STATE_DONE = 3'd4
   } state_t;

endpackage

// File: rtl/imuldiv_mul_accum_if.sv
// Command, operand, multiplier and result handshakes of the accumulator.
// IMULDIV_MUL_ACCUM_OVF_EN adds the acc_ovf signal.
interface imuldiv_mul_accum_if
   import imuldiv_mul_accum_pkg::*;
#(
   parameter int unsigned LEN_W = 8
);

   logic [LEN_W-1:0]  cmd_len;
   logic              cmd_val;
   logic              cmd_rdy;

   logic [OPND_W-1:0] opnd_a;
   logic [OPND_W-1:0] opnd_b;
   logic              opnd_val;
   logic              opnd_rdy;

   logic [OPND_W-1:0] mulreq_msg_a;
   logic [OPND_W-1:0] mulreq_msg_b;
   logic              mulreq_val;
   logic              mulreq_rdy;

   logic [PROD_W-1:0] mulresp_msg_result;
   logic              mulresp_val;
   logic              mulresp_rdy;

   logic [PROD_W-1:0] acc_msg;
   logic              acc_val;
   logic              acc_rdy;

   logic              busy;
`ifdef IMULDIV_MUL_ACCUM_OVF_EN
   logic              acc_ovf;
`endif

   modport master (
      input  cmd_len, cmd_val, opnd_a, opnd_b, opnd_val, mulreq_rdy,
             mulresp_msg_result, mulresp_val, acc_rdy,
      output cmd_rdy, opnd_rdy, mulreq_msg_a, mulreq_msg_b, mulreq_val,
             mulresp_rdy, acc_msg, acc_val, busy
`ifdef IMULDIV_MUL_ACCUM_OVF_EN
      , output acc_ovf
`endif
   );

   modport slave (
      output cmd_len, cmd_val, opnd_a, opnd_b, opnd_val, mulreq_rdy,
             mulresp_msg_result, mulresp_val, acc_rdy,
      input  cmd_rdy, opnd_rdy, mulreq_msg_a, mulreq_msg_b, mulreq_val,
             mulresp_rdy, acc_msg, acc_val, busy
`ifdef IMULDIV_MUL_ACCUM_OVF_EN
      , input acc_ovf
`endif
   );

endinterface

// File: rtl/imuldiv_mul_accum_dpath.sv
// Datapath: request operand registers, 64-bit accumulator, remaining-pair counter.
// IMULDIV_MUL_ACCUM_OVF_EN adds the sticky signed-overflow flag.
module imuldiv_mul_accum_dpath
   import imuldiv_mul_accum_pkg::*;
#(
   parameter int unsigned LEN_W = 8
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              i_cmd_go,
   input  logic [LEN_W-1:0]  i_cmd_len,
   input  logic              i_opnd_go,
   input  logic [OPND_W-1:0] i_opnd_a,
   input  logic [OPND_W-1:0] i_opnd_b,
   input  logic              i_resp_go,
   input  logic [PROD_W-1:0] i_resp_result,
   output logic [OPND_W-1:0] o_req_a,
   output logic [OPND_W-1:0] o_req_b,
   output logic [PROD_W-1:0] o_acc,
   output logic              o_rem_last
`ifdef IMULDIV_MUL_ACCUM_OVF_EN
   , output logic            o_ovf
`endif
);

   logic [OPND_W-1:0] r_req_a;
   logic [OPND_W-1:0] r_req_b;
   logic [PROD_W-1:0] r_acc;
   logic [LEN_W-1:0]  r_rem;
   logic [PROD_W-1:0] w_sum;

   assign w_sum = r_acc + i_resp_result;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_req_a <= '0;
         r_req_b <= '0;
         r_acc   <= '0;
         r_rem   <= '0;
      end else begin
         if (i_cmd_go) begin
            r_rem <= i_cmd_len;
            r_acc <= '0;
         end
         if (i_opnd_go) begin
            r_req_a <= i_opnd_a;
            r_req_b <= i_opnd_b;
         end
         if (i_resp_go) begin
            r_acc <= w_sum;
            r_rem <= r_rem - LEN_W'(1);
         end
      end
   end

   assign o_req_a    = r_req_a;
   assign o_req_b    = r_req_b;
   assign o_acc      = r_acc;
   assign o_rem_last = (r_rem == LEN_W'(1));

`ifdef IMULDIV_MUL_ACCUM_OVF_EN
   logic r_ovf;
   logic w_step_ovf;

   // Same-sign addends whose sum flips sign: signed overflow; sum still wraps.
   assign w_step_ovf = (r_acc[PROD_W-1] == i_resp_result[PROD_W-1]) &&
                       (w_sum[PROD_W-1] != r_acc[PROD_W-1]);

   always_ff @(posedge clk) begin
      if (reset || i_cmd_go) begin
         r_ovf <= 1'b0;
      end else if (i_resp_go && w_step_ovf) begin
         r_ovf <= 1'b1;
      end
   end

   assign o_ovf = r_ovf;
`endif

endmodule

// File: rtl/imuldiv_mul_accum_initiator.sv
// Requester for the iterative multiplier: one request in flight, products summed.
// Optional build macro IMULDIV_MUL_ACCUM_OVF_EN exposes acc_ovf.
module imuldiv_mul_accum_initiator
   import imuldiv_mul_accum_pkg::*;
#(
   parameter int unsigned LEN_W = 8
)(
   input  logic                clk,
   input  logic                reset,
   imuldiv_mul_accum_if.master bus
);

   state_t r_state;
   logic   r_cmd_rdy;
   logic   r_opnd_rdy;
   logic   r_mulreq_val;
   logic   r_mulresp_rdy;
   logic   r_acc_val;
   logic   r_busy;

   logic   w_cmd_go;
   logic   w_opnd_go;
   logic   w_req_go;
   logic   w_resp_go;
   logic   w_acc_go;
   logic   w_len_zero;
   logic   w_rem_last;

   assign w_cmd_go   = bus.cmd_val     & r_cmd_rdy;
   assign w_opnd_go  = bus.opnd_val    & r_opnd_rdy;
   assign w_req_go   = r_mulreq_val    & bus.mulreq_rdy;
   assign w_resp_go  = bus.mulresp_val & r_mulresp_rdy;
   assign w_acc_go   = r_acc_val       & bus.acc_rdy;
   assign w_len_zero = (bus.cmd_len == '0);

   // Handshake outputs are registered and set on the transition into each state.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= STATE_IDLE;
         r_cmd_rdy     <= 1'b1;
         r_opnd_rdy    <= 1'b0;
         r_mulreq_val  <= 1'b0;
         r_mulresp_rdy <= 1'b0;
         r_acc_val     <= 1'b0;
         r_busy        <= 1'b0;
      end else begin
         case (r_state)
            STATE_IDLE: if (w_cmd_go) begin
               r_cmd_rdy <= 1'b0;
               r_busy    <= 1'b1;
               if (w_len_zero) begin
                  r_state   <= STATE_DONE;
                  r_acc_val <= 1'b1;
               end else begin
                  r_state    <= STATE_LOAD;
                  r_opnd_rdy <= 1'b1;
               end
            end
            STATE_LOAD: if (w_opnd_go) begin
               r_state      <= STATE_REQ;
               r_opnd_rdy   <= 1'b0;
               r_mulreq_val <= 1'b1;
            end
            STATE_REQ: if (w_req_go) begin
               r_state       <= STATE_WAIT;
               r_mulreq_val  <= 1'b0;
               r_mulresp_rdy <= 1'b1;
            end
            STATE_WAIT: if (w_resp_go) begin
               r_mulresp_rdy <= 1'b0;
               if (w_rem_last) begin
                  r_state   <= STATE_DONE;
                  r_acc_val <= 1'b1;
               end else begin
                  r_state    <= STATE_LOAD;
                  r_opnd_rdy <= 1'b1;
               end
            end
            STATE_DONE: if (w_acc_go) begin
               r_state   <= STATE_IDLE;
               r_acc_val <= 1'b0;
               r_busy    <= 1'b0;
               r_cmd_rdy <= 1'b1;
            end
            default: begin
               r_state       <= STATE_IDLE;
               r_cmd_rdy     <= 1'b1;
               r_opnd_rdy    <= 1'b0;
               r_mulreq_val  <= 1'b0;
               r_mulresp_rdy <= 1'b0;
               r_acc_val     <= 1'b0;
               r_busy        <= 1'b0;
            end
         endcase
      end
   end

`ifdef IMULDIV_MUL_ACCUM_OVF_EN
   logic w_ovf;
`endif

   imuldiv_mul_accum_dpath #(
      .LEN_W (LEN_W)
   ) u_dpath (
      .clk           (clk),
      .reset         (reset),
      .i_cmd_go      (w_cmd_go),
      .i_cmd_len     (bus.cmd_len),
      .i_opnd_go     (w_opnd_go),
      .i_opnd_a      (bus.opnd_a),
      .i_opnd_b      (bus.opnd_b),
      .i_resp_go     (w_resp_go),
      .i_resp_result (bus.mulresp_msg_result),
      .o_req_a       (bus.mulreq_msg_a),
      .o_req_b       (bus.mulreq_msg_b),
      .o_acc         (bus.acc_msg),
      .o_rem_last    (w_rem_last)
`ifdef IMULDIV_MUL_ACCUM_OVF_EN
      , .o_ovf       (w_ovf)
`endif
   );

   assign bus.cmd_rdy     = r_cmd_rdy;
   assign bus.opnd_rdy    = r_opnd_rdy;
   assign bus.mulreq_val  = r_mulreq_val;
   assign bus.mulresp_rdy = r_mulresp_rdy;
   assign bus.acc_val     = r_acc_val;
   assign bus.busy        = r_busy;
`ifdef IMULDIV_MUL_ACCUM_OVF_EN
   assign bus.acc_ovf     = w_ovf;
`endif

endmodule

// File: tb/tb_imuldiv_mul_accum_initiator.sv
// Directed bench: the bench plays operand source, multiplier and result sink.
// Build with IMULDIV_MUL_ACCUM_OVF_EN to also check acc_ovf.
`timescale 1ns/1ps
module tb_imuldiv_mul_accum_initiator;

   localparam logic [63:0] JUNK = 64'h0123_4567_89AB_CDEF;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   imuldiv_mul_accum_if #(.LEN_W(8)) bus ();

   imuldiv_mul_accum_initiator #(.LEN_W(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   logic [31:0] va [256];
   logic [31:0] vb [256];
   logic [31:0] ra [256];
   logic [31:0] rb [256];
   int unsigned n_opnd, n_req, n_resp, acc_cycle;
   logic [63:0] got_acc;
   logic timed_out, req_unstable, acc_unstable, bad_req, rdy_while_busy;
   logic any_req, any_opnd, first_acc_val, first_busy;
`ifdef IMULDIV_MUL_ACCUM_OVF_EN
   logic got_ovf;
`endif

   task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.cmd_val            = 1'b0;
      bus.cmd_len            = '0;
      bus.opnd_val           = 1'b0;
      bus.opnd_a             = '0;
      bus.opnd_b             = '0;
      bus.mulreq_rdy         = 1'b0;
      bus.mulresp_val        = 1'b0;
      bus.mulresp_msg_result = '0;
      bus.acc_rdy            = 1'b0;
   endtask

   // Issues one command and services it until the result is taken or the budget runs out.
   task automatic run_cmd(input logic [7:0] len, input int unsigned opnd_stall,
                          input int unsigned req_stall, input int unsigned acc_stall,
                          input int unsigned mul_lat, input logic hold_cmd);
      int unsigned ow, rw, aw, lat_ctr;
      logic pend, done, req_held, acc_held;
      logic [63:0] prod, sa, sb, hold_acc;
      logic [31:0] hold_a, hold_b;
      n_opnd = 0; n_req = 0; n_resp = 0; acc_cycle = 0;
      got_acc = '0; timed_out = 1'b0; req_unstable = 1'b0; acc_unstable = 1'b0;
      bad_req = 1'b0; rdy_while_busy = 1'b0; any_req = 1'b0; any_opnd = 1'b0;
      ow = 0; rw = 0; aw = 0; lat_ctr = 0; pend = 1'b0; done = 1'b0;
      req_held = 1'b0; acc_held = 1'b0; prod = '0;
      hold_a = '0; hold_b = '0; hold_acc = '0;
      bus.mulresp_val = 1'b1;
      bus.mulresp_msg_result = JUNK;
      bus.cmd_len = len;
      bus.cmd_val = 1'b1;
      step();
      bus.cmd_val = hold_cmd;
      bus.cmd_len = 8'd5;
      for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
         if (cyc == 0) begin
            first_acc_val = bus.acc_val;
            first_busy    = bus.busy;
         end
         bus.opnd_val           = (n_opnd < len) && (ow >= opnd_stall);
         bus.opnd_a             = va[n_opnd % 256];
         bus.opnd_b             = vb[n_opnd % 256];
         bus.mulreq_rdy         = (rw >= req_stall);
         bus.mulresp_val        = pend ? (lat_ctr == 0) : 1'b1;
         bus.mulresp_msg_result = pend ? prod : JUNK;
         bus.acc_rdy            = (aw >= acc_stall);

         if (req_held && (!bus.mulreq_val || bus.mulreq_msg_a != hold_a ||
                          bus.mulreq_msg_b != hold_b)) req_unstable = 1'b1;
         if (acc_held && (!bus.acc_val || bus.acc_msg != hold_acc)) acc_unstable = 1'b1;
         req_held = bus.mulreq_val && !bus.mulreq_rdy;
         acc_held = bus.acc_val && !bus.acc_rdy;
         hold_a = bus.mulreq_msg_a; hold_b = bus.mulreq_msg_b; hold_acc = bus.acc_msg;
         if (bus.mulreq_val && n_req >= n_opnd) bad_req = 1'b1;
         if (bus.cmd_rdy && bus.busy) rdy_while_busy = 1'b1;
         any_req  = any_req  | bus.mulreq_val;
         any_opnd = any_opnd | bus.opnd_rdy;

         if (bus.mulresp_val && bus.mulresp_rdy) begin
            n_resp++;
            pend = 1'b0;
         end else if (pend && lat_ctr != 0) begin
            lat_ctr--;
         end
         if (bus.mulreq_val && bus.mulreq_rdy) begin
            ra[n_req % 256] = bus.mulreq_msg_a;
            rb[n_req % 256] = bus.mulreq_msg_b;
            n_req++;
            sa = {{32{bus.mulreq_msg_a[31]}}, bus.mulreq_msg_a};
            sb = {{32{bus.mulreq_msg_b[31]}}, bus.mulreq_msg_b};
            prod = sa * sb;
            pend = 1'b1;
            lat_ctr = mul_lat - 1;
            rw = 0;
         end else if (bus.mulreq_val) begin
            rw++;
         end
         if (bus.opnd_val && bus.opnd_rdy) begin
            n_opnd++;
            ow = 0;
         end else if (bus.opnd_rdy) begin
            ow++;
         end
         if (bus.acc_val && bus.acc_rdy) begin
            got_acc   = bus.acc_msg;
`ifdef IMULDIV_MUL_ACCUM_OVF_EN
            got_ovf   = bus.acc_ovf;
`endif
            acc_cycle = cyc;
            done      = 1'b1;
            bus.cmd_val = 1'b0;
         end else if (bus.acc_val) begin
            aw++;
         end
         step();
      end
      timed_out = !done;
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      reset = 1'b1;
      repeat (3) step();
      reset = 1'b0;

      chk_eq("rst_cmd_rdy",     64'(bus.cmd_rdy),     64'd1);
      chk_eq("rst_opnd_rdy",    64'(bus.opnd_rdy),    64'd0);
      chk_eq("rst_mulreq_val",  64'(bus.mulreq_val),  64'd0);
      chk_eq("rst_mulresp_rdy", 64'(bus.mulresp_rdy), 64'd0);
      chk_eq("rst_acc_val",     64'(bus.acc_val),     64'd0);
      chk_eq("rst_busy",        64'(bus.busy),        64'd0);
      chk_eq("rst_acc_msg",     bus.acc_msg,          64'd0);
      chk_eq("rst_req_a",       64'(bus.mulreq_msg_a), 64'd0);
      chk_eq("rst_req_b",       64'(bus.mulreq_msg_b), 64'd0);

      // 1: single pair, 3 * -4
      va[0] = 32'd3; vb[0] = 32'hFFFF_FFFC;
      run_cmd(8'd1, 0, 0, 0, 1, 1'b0);
      chk_eq("t1_timeout", 64'(timed_out), 64'd0);
      chk_eq("t1_acc",     got_acc, 64'hFFFF_FFFF_FFFF_FFF4);
      chk_eq("t1_nreq",    64'(n_req),  64'd1);
      chk_eq("t1_nresp",   64'(n_resp), 64'd1);
      chk_eq("t1_req_a",   64'(ra[0]),  64'd3);
      chk_eq("t1_req_b",   64'(rb[0]),  64'hFFFF_FFFC);
      chk_eq("t1_cycles",  64'(acc_cycle), 64'd3);

      // 2: three pairs, multiplier latency 3, cmd_val held high while busy
      va[0] = 32'd2;          vb[0] = 32'd5;
      va[1] = 32'hFFFF_FFF9;  vb[1] = 32'd6;
      va[2] = 32'h7FFF_FFFF;  vb[2] = 32'd2;
      run_cmd(8'd3, 0, 0, 0, 3, 1'b1);
      chk_eq("t2_timeout", 64'(timed_out), 64'd0);
      chk_eq("t2_acc",     got_acc, 64'h0000_0000_FFFF_FFDE);
      chk_eq("t2_nreq",    64'(n_req), 64'd3);
      for (int i = 0; i < 3; i++) begin
         chk_eq("t2_req_a", 64'(ra[i]), 64'(va[i]));
         chk_eq("t2_req_b", 64'(rb[i]), 64'(vb[i]));
      end
      chk_eq("t2_cycles",       64'(acc_cycle), 64'd15);
      chk_eq("t2_rdy_when_busy", 64'(rdy_while_busy), 64'd0);
      chk_eq("t2_back_idle",    64'(bus.cmd_rdy), 64'd1);

      // 3: zero-length command
      run_cmd(8'd0, 0, 0, 0, 1, 1'b0);
      chk_eq("t3_timeout",   64'(timed_out), 64'd0);
      chk_eq("t3_acc_val_1", 64'(first_acc_val), 64'd1);
      chk_eq("t3_busy",      64'(first_busy), 64'd1);
      chk_eq("t3_acc",       got_acc, 64'd0);
      chk_eq("t3_cycles",    64'(acc_cycle), 64'd0);
      chk_eq("t3_no_req",    64'(any_req), 64'd0);
      chk_eq("t3_no_opnd",   64'(any_opnd), 64'd0);
      chk_eq("t3_nresp",     64'(n_resp), 64'd0);

      // 4: backpressure on all three sides; 5*-3 + -6*-9 = 39
      va[0] = 32'd5;          vb[0] = 32'hFFFF_FFFD;
      va[1] = 32'hFFFF_FFFA;  vb[1] = 32'hFFFF_FFF7;
      run_cmd(8'd2, 3, 5, 4, 2, 1'b0);
      chk_eq("t4_timeout",   64'(timed_out), 64'd0);
      chk_eq("t4_acc",       got_acc, 64'd39);
      chk_eq("t4_req_hold",  64'(req_unstable), 64'd0);
      chk_eq("t4_acc_hold",  64'(acc_unstable), 64'd0);
      chk_eq("t4_early_req", 64'(bad_req), 64'd0);
      chk_eq("t4_cycles",    64'(acc_cycle), 64'd28);

      // 5: reset while waiting on the multiplier
      bus.cmd_len = 8'd2; bus.cmd_val = 1'b1;
      step();
      bus.cmd_val = 1'b0;
      bus.opnd_a = 32'd1; bus.opnd_b = 32'd1; bus.opnd_val = 1'b1;
      step();
      bus.opnd_val = 1'b0;
      bus.mulreq_rdy = 1'b1;
      step();
      bus.mulreq_rdy = 1'b0;
      chk_eq("t5_in_wait", 64'(bus.mulresp_rdy), 64'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk_eq("t5_cmd_rdy",     64'(bus.cmd_rdy), 64'd1);
      chk_eq("t5_busy",        64'(bus.busy), 64'd0);
      chk_eq("t5_mulresp_rdy", 64'(bus.mulresp_rdy), 64'd0);
      va[0] = 32'd1; vb[0] = 32'd1;
      run_cmd(8'd1, 0, 0, 0, 1, 1'b0);
      chk_eq("t5_acc", got_acc, 64'd1);

      // 6: 2^62 + 2^62 wraps to the sign bit
      va[0] = 32'h8000_0000; vb[0] = 32'h8000_0000;
      va[1] = 32'h8000_0000; vb[1] = 32'h8000_0000;
      run_cmd(8'd2, 0, 0, 0, 1, 1'b0);
      chk_eq("t6_acc", got_acc, 64'h8000_0000_0000_0000);
`ifdef IMULDIV_MUL_ACCUM_OVF_EN
      chk_eq("t6_ovf_set", 64'(got_ovf), 64'd1);
`endif
      va[0] = 32'd1; vb[0] = 32'd1;
      run_cmd(8'd1, 0, 0, 0, 1, 1'b0);
      chk_eq("t6_acc2", got_acc, 64'd1);
`ifdef IMULDIV_MUL_ACCUM_OVF_EN
      chk_eq("t6_ovf_clr", 64'(got_ovf), 64'd0);
`endif

      // 7: maximum length, a=i b=2 -> 2*sum(0..254) = 64770
      for (int i = 0; i < 256; i++) begin
         va[i] = 32'(i);
         vb[i] = 32'd2;
      end
      run_cmd(8'd255, 0, 0, 0, 1, 1'b0);
      chk_eq("t7_timeout", 64'(timed_out), 64'd0);
      chk_eq("t7_acc",     got_acc, 64'hFD02);
      chk_eq("t7_nreq",    64'(n_req), 64'd255);
      chk_eq("t7_nresp",   64'(n_resp), 64'd255);
      chk_eq("t7_cycles",  64'(acc_cycle), 64'd765);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
